layer_coinc_trigger: RTL and testbench
======================================

Name: layer_coinc_trigger

Overview:
- Parametrised successor to the fixed 64-input trigger logic in the distribution-board firmware.
- Channels are arranged as NLAYER layers × NCOL columns; channel index = layer*NCOL + col.
- Per-channel coincidence windows feed a selectable decision (column majority, total multiplicity, or any-hit). Firing is gated by busy veto, prescale and deadtime.
- Outputs a stretched trigger pulse plus fired/vetoed counters and a latched timestamp for readout over the slow-control path.

Parameters:
- NLAYER, 4, number of detector layers (≥2)
- NCOL, 16, channels per layer; NCH = NLAYER*NCOL
- TSW, 56, width of free-running timestamp counter
- WINW, 8, width of coincidence-window and deadtime counters
- ACT_MIN, 2, window counter must exceed this for a channel to count as active

Ports:
- clk_adc  in  1  trigger clock; all logic in this domain
- reset  in  1  synchronous, active-high; clears all state
- coax_in  in  NCH  raw LVDS/coax hits, active-low (unconnected = idle)
- triggermask  in  NCH  1 = channel enabled; masked channel is forced idle
- busy  in  1  DAQ busy, active-high; blocks firing
- coincidence_time  in  WINW  window length in clk ticks
- layer_threshold  in  $clog2(NLAYER+1)  minimum active layers per column (mode 0)
- mult_threshold  in  $clog2(NCH+1)  minimum total active channels (mode 1)
- trig_mode  in  2  0 = column majority, 1 = multiplicity, 2 = any hit, 3 = disabled
- prescale  in  32  accept when randnum ≤ prescale
- randnum  in  32  external PRNG value
- dead_time  in  WINW  ticks blocked after a fire
- out_width  in  6  trig_out pulse length; 0 treated as 1
- trig_out  out  1  stretched trigger output
- trig_count  out  32  number of fires
- veto_count  out  32  candidates lost to busy or prescale
- trig_timestamp  out  TSW  timestamp value at last fire
- trig_column  out  $clog2(NCOL)  lowest firing column at last fire; 0 in modes 1/2

Behaviour:
- Reset values: all outputs and internal counters 0, including the timestamp counter. Reset asserted mid-pulse drops trig_out on the next edge.
- Stage 0 (edge E0): hit_r[i] <= ~coax_in[i] & triggermask[i].
- Stage 1 (E1):
  - If hit_r[i], win[i] <= coincidence_time.
  - Else, if win[i] > 0, win[i] decrements by 1.
  - active[i] = win[i] > ACT_MIN (combinational from the registered win).
- Stage 2 (E2): registered values
  - colcnt[c] = number of active layers in column c;
  - total = number of active channels;
  - pass_r <= (randnum ≤ prescale), unsigned.
- Stage 3 (E3), candidate by mode:
  - mode 0: any colcnt ≥ layer_threshold (layer_threshold 0 treated as 1);
  - mode 1: total ≥ mult_threshold (mult_threshold 0 treated as 1);
  - mode 2: total ≥ 1;
  - mode 3: never a candidate.
- Fire condition: candidate & dead == 0 & !busy & pass_r.
- On fire:
  - pulse counter <= max(out_width, 1);
  - dead <= dead_time;
  - trig_count += 1 (wraps at 2^32);
  - trig_timestamp <= ts;
  - trig_column <= lowest c meeting the threshold.
- Candidate with dead == 0 but busy or !pass_r: veto_count += 1 (wraps). Deadtime is not started; the candidate is re-evaluated next cycle.
- Candidate with dead > 0: ignored, no count.
- trig_out = pulse counter ≠ 0 (registered). Latency: hit sampled at E0 → trig_out high after E3 with nominal thresholds. Pulse lasts exactly max(out_width, 1) cycles.
- dead decrements every cycle while > 0. dead_time = 0 allows a fire on every cycle the condition holds.
- A re-fire while a pulse is still running reloads the pulse counter; the pulse extends and is not doubled.
- ts increments every cycle and wraps at 2^TSW.
- Config inputs are used as sampled each cycle; changing them mid-window takes effect on the next cycle.
- A hit arriving while win[i] > 0 reloads the window (retrigger).
- win never underflows.

Test Plan:
- Mode 0, NLAYER=4, layer_threshold=4, coincidence_time=8, prescale=max: hit column 5 on all layers in one cycle → trig_out high 3 cycles later for out_width=16 cycles; trig_count=1; trig_column=5.
- Same config, hits on layers 0-3 of column 5 staggered by 2 cycles each → fires. Stagger by 6 cycles → no fire; veto_count stays 0.
- Mode 1, mult_threshold=2, dead_time=20: continuous hits on channels 0 and 1 → fires spaced exactly 21 cycles apart.
- busy=1 during a valid coincidence lasting 4 cycles → no trig_out, veto_count=4. Release busy while still active → fires the next cycle.
- prescale=0, randnum=5 → candidates vetoed. randnum=0 → fires. triggermask bit cleared → that channel never contributes.
- Assert reset for 1 cycle mid-pulse → trig_out=0 next cycle; counters, timestamp and windows all 0. Mode 3 → never fires.

Source files
------------

// File: rtl/layer_coinc_trigger_if.sv
// rtl/layer_coinc_trigger_if.sv - trigger hit, configuration and result signals
interface layer_coinc_trigger_if #(
  parameter int NLAYER = 4,
  parameter int NCOL   = 16,
  parameter int TSW    = 56,
  parameter int WINW   = 8
);
  localparam int NCH = NLAYER * NCOL;
  localparam int LTW = $clog2(NLAYER + 1);
  localparam int MTW = $clog2(NCH + 1);
  localparam int CW  = (NCOL > 1) ? $clog2(NCOL) : 1;

  logic [NCH-1:0]  coax_in;
  logic [NCH-1:0]  triggermask;
  logic            busy;
  logic [WINW-1:0] coincidence_time;
  logic [LTW-1:0]  layer_threshold;
  logic [MTW-1:0]  mult_threshold;
  logic [1:0]      trig_mode;
  logic [31:0]     prescale;
  logic [31:0]     randnum;
  logic [WINW-1:0] dead_time;
  logic [5:0]      out_width;

  logic            trig_out;
  logic [31:0]     trig_count;
  logic [31:0]     veto_count;
  logic [TSW-1:0]  trig_timestamp;
  logic [CW-1:0]   trig_column;

  modport master (
    output coax_in, triggermask, busy, coincidence_time, layer_threshold,
           mult_threshold, trig_mode, prescale, randnum, dead_time, out_width,
    input  trig_out, trig_count, veto_count, trig_timestamp, trig_column
  );

  modport slave (
    input  coax_in, triggermask, busy, coincidence_time, layer_threshold,
           mult_threshold, trig_mode, prescale, randnum, dead_time, out_width,
    output trig_out, trig_count, veto_count, trig_timestamp, trig_column
  );
endinterface

// File: rtl/layer_coinc_trigger.sv
// rtl/layer_coinc_trigger.sv - layered coincidence trigger with veto, prescale and deadtime
module layer_coinc_trigger #(
  parameter int NLAYER  = 4,
  parameter int NCOL    = 16,
  parameter int TSW     = 56,
  parameter int WINW    = 8,
  parameter int ACT_MIN = 2
) (
  input logic              clk_adc,
  input logic              reset,
  layer_coinc_trigger_if.slave bus
);
  localparam int NCH = NLAYER * NCOL;
  localparam int LTW = $clog2(NLAYER + 1);
  localparam int MTW = $clog2(NCH + 1);
  localparam int CW  = (NCOL > 1) ? $clog2(NCOL) : 1;

  // Stage 0/1 state: sampled hits and per-channel coincidence windows
  logic [NCH-1:0]  r_hit;
  logic [WINW-1:0] r_win [NCH];
  logic [NCH-1:0]  w_active;

  // Stage 2 state: per-column layer counts, total multiplicity, prescale pass
  logic [LTW-1:0]  w_colcnt_next [NCOL];
  logic [MTW-1:0]  w_total_next;
  logic [LTW-1:0]  r_colcnt [NCOL];
  logic [MTW-1:0]  r_total;
  logic            r_pass;

  // Stage 3 decision
  logic [LTW-1:0]  w_lthr;
  logic [MTW-1:0]  w_mthr;
  logic [NCOL-1:0] w_col_ok;
  logic [CW-1:0]   w_first_col;
  logic            w_cand;
  logic            w_fire;
  logic            w_veto;
  logic [5:0]      w_pulse_len;

  // Output-side state
  logic [5:0]      r_pulse;
  logic            r_trig_out;
  logic [WINW-1:0] r_dead;
  logic [31:0]     r_trig_count;
  logic [31:0]     r_veto_count;
  logic [TSW-1:0]  r_ts;
  logic [TSW-1:0]  r_trig_timestamp;
  logic [CW-1:0]   r_trig_column;

  // Channel counts as active while its window is above the noise floor
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NCH; i++) begin
      w_active[i] = (r_win[i] > WINW'(ACT_MIN));
    end
  end

  // Stage 0 hit sampling (inputs are active-low) and stage 1 window reload/decay
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_hit <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_hit <= ~bus.coax_in & bus.triggermask;
      for (int i = 0; i < NCH; i++) begin
        if (r_hit[i]) begin
          r_win[i] <= bus.coincidence_time;
        end else if (r_win[i] != '0) begin
          r_win[i] <= r_win[i] - 1'b1;
        end
      end
    end
  end

  // Column and total population counts of the active channels
  always_comb begin
    w_total_next = '0;
    for (int c = 0; c < NCOL; c++) begin
      w_colcnt_next[c] = '0;
    end
    for (int l = 0; l < NLAYER; l++) begin
      for (int c = 0; c < NCOL; c++) begin
        w_colcnt_next[c] = w_colcnt_next[c] + LTW'(w_active[l*NCOL + c]);
        w_total_next     = w_total_next + MTW'(w_active[l*NCOL + c]);
      end
    end
  end

  // Stage 2 registers the counts and the prescale lottery result
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      for (int c = 0; c < NCOL; c++) begin
        r_colcnt[c] <= '0;
      end
      r_total <= '0;
      r_pass  <= 1'b0;
    end else begin
      for (int c = 0; c < NCOL; c++) begin
        r_colcnt[c] <= w_colcnt_next[c];
      end
      r_total <= w_total_next;
      r_pass  <= (bus.randnum <= bus.prescale);
    end
  end

  // Stage 3 candidate selection by mode; zero thresholds behave as one
  always_comb begin
    w_lthr      = (bus.layer_threshold == '0) ? LTW'(1) : bus.layer_threshold;
    w_mthr      = (bus.mult_threshold == '0) ? MTW'(1) : bus.mult_threshold;
    w_col_ok    = '0;
    w_first_col = '0;
    for (int c = 0; c < NCOL; c++) begin
      w_col_ok[c] = (r_colcnt[c] >= w_lthr);
    end
    for (int c = NCOL - 1; c >= 0; c--) begin
      if (w_col_ok[c]) begin
        w_first_col = CW'(c);
      end
    end
    case (bus.trig_mode)
      2'd0:    w_cand = |w_col_ok;
      2'd1:    w_cand = (r_total >= w_mthr);
      2'd2:    w_cand = (r_total != '0);
      default: w_cand = 1'b0;
    endcase
    w_fire      = w_cand && (r_dead == '0) && !bus.busy && r_pass;
    w_veto      = w_cand && (r_dead == '0) && (bus.busy || !r_pass);
    w_pulse_len = (bus.out_width == '0) ? 6'd1 : bus.out_width;
  end

  // Fire bookkeeping: pulse stretcher, deadtime, counters and latched readout
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_pulse          <= '0;
      r_trig_out       <= 1'b0;
      r_dead           <= '0;
      r_trig_count     <= '0;
      r_veto_count     <= '0;
      r_trig_timestamp <= '0;
      r_trig_column    <= '0;
    end else begin
      if (w_fire) begin
        r_pulse          <= w_pulse_len;
        r_trig_out       <= 1'b1;
        r_dead           <= bus.dead_time;
        r_trig_count     <= r_trig_count + 32'd1;
        r_trig_timestamp <= r_ts;
        r_trig_column    <= (bus.trig_mode == 2'd0) ? w_first_col : '0;
      end else begin
        if (r_pulse != '0) begin
          r_pulse <= r_pulse - 6'd1;
        end
        r_trig_out <= (r_pulse > 6'd1);
        if (r_dead != '0) begin
          r_dead <= r_dead - 1'b1;
        end
      end
      if (w_veto) begin
        r_veto_count <= r_veto_count + 32'd1;
      end
    end
  end

  // Free-running timestamp
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  assign bus.trig_out       = r_trig_out;
  assign bus.trig_count     = r_trig_count;
  assign bus.veto_count     = r_veto_count;
  assign bus.trig_timestamp = r_trig_timestamp;
  assign bus.trig_column    = r_trig_column;
endmodule

// File: tb/tb_layer_coinc_trigger.sv
// tb/tb_layer_coinc_trigger.sv - scoreboard bench for layer_coinc_trigger
module tb_layer_coinc_trigger;
  localparam int NL  = 4;
  localparam int NC  = 16;
  localparam int NCH = NL * NC;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic [3:0]  col;
    logic [55:0] ts;
    int          width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_coinc_trigger_if u_if ();

  layer_coinc_trigger dut (
    .clk_adc (clk),
    .reset   (rst),
    .bus     (u_if)
  );

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rst_cyc  = 0;
  logic prev_out = 1'b0;
  int   hi_cnt   = 0;
  logic have_cur = 1'b0;
  int   c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int fc, input int cnt, input int col, input int width);
    exp_t e;
    e.cyc   = fc;
    e.cnt   = 32'(cnt);
    e.col   = 4'(col);
    e.ts    = 56'(fc - 1 - rst_cyc);
    e.width = width;
    sb_q.push_back(e);
  endtask

  task automatic hit_col(input int col);
    for (int l = 0; l < NL; l++) u_if.coax_in[l*NC + col] = 1'b0;
  endtask

  // Monitor: every rising trig_out must match the head of the scoreboard
  always @(negedge clk) begin
    if (u_if.trig_out && !prev_out) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fire: trigger at cycle %0d with empty scoreboard", cyc);
      end else begin
        cur = sb_q.pop_front();
        check("fire_cycle", 64'(cyc), 64'(cur.cyc));
        check("fire_count", 64'(u_if.trig_count), 64'(cur.cnt));
        check("fire_column", 64'(u_if.trig_column), 64'(cur.col));
        check("fire_timestamp", 64'(u_if.trig_timestamp), 64'(cur.ts));
        have_cur = 1'b1;
      end
      hi_cnt = 1;
    end else if (u_if.trig_out) begin
      hi_cnt++;
    end else if (prev_out && have_cur) begin
      check("pulse_width", 64'(hi_cnt), 64'(cur.width));
      have_cur = 1'b0;
    end
    prev_out = u_if.trig_out;
  end

  initial begin
    u_if.coax_in          = '1;
    u_if.triggermask      = '1;
    u_if.busy             = 1'b0;
    u_if.coincidence_time = 8'd8;
    u_if.layer_threshold  = 3'd4;
    u_if.mult_threshold   = 7'd2;
    u_if.trig_mode        = 2'd0;
    u_if.prescale         = 32'hFFFF_FFFF;
    u_if.randnum          = 32'd0;
    u_if.dead_time        = 8'd40;
    u_if.out_width        = 6'd16;

    rst = 1'b1;
    step(2);
    rst_cyc = cyc;
    rst = 1'b0;
    check("reset_trig_out", 64'(u_if.trig_out), 64'd0);
    check("reset_trig_count", 64'(u_if.trig_count), 64'd0);
    check("reset_veto_count", 64'(u_if.veto_count), 64'd0);
    check("reset_timestamp", 64'(u_if.trig_timestamp), 64'd0);
    check("reset_column", 64'(u_if.trig_column), 64'd0);

    // Mode 0, all four layers of column 5 together
    c0 = cyc;
    hit_col(5);
    push(c0 + 4, 1, 5, 16);
    step(1);
    u_if.coax_in = '1;
    step(60);
    check("m0_count", 64'(u_if.trig_count), 64'd1);
    check("m0_veto", 64'(u_if.veto_count), 64'd0);
    check("m0_column", 64'(u_if.trig_column), 64'd5);

    // Layers staggered by 2 cycles (2-cycle hits) still overlap
    c0 = cyc;
    push(c0 + 10, 2, 5, 16);
    for (int s = 0; s < 8; s++) begin
      u_if.coax_in = '1;
      u_if.coax_in[(s/2)*NC + 5] = 1'b0;
      step(1);
    end
    u_if.coax_in = '1;
    step(60);
    check("stagger2_count", 64'(u_if.trig_count), 64'd2);

    // Staggered by 6 cycles: windows never overlap on all four layers
    for (int s = 0; s < 24; s++) begin
      u_if.coax_in = '1;
      if ((s % 6) < 2) u_if.coax_in[(s/6)*NC + 5] = 1'b0;
      step(1);
    end
    u_if.coax_in = '1;
    step(40);
    check("stagger6_count", 64'(u_if.trig_count), 64'd2);
    check("stagger6_veto", 64'(u_if.veto_count), 64'd0);

    // Mode 1 with continuous hits on channels 0 and 1: fires 21 cycles apart
    u_if.trig_mode = 2'd1;
    u_if.dead_time = 8'd20;
    u_if.out_width = 6'd4;
    c0 = cyc;
    push(c0 + 4, 3, 0, 4);
    push(c0 + 25, 4, 0, 4);
    push(c0 + 46, 5, 0, 4);
    u_if.coax_in[0] = 1'b0;
    u_if.coax_in[1] = 1'b0;
    step(50);
    u_if.coax_in = '1;
    step(30);
    check("mult_count", 64'(u_if.trig_count), 64'd5);
    check("mult_column", 64'(u_if.trig_column), 64'd0);

    // Busy for the first four candidate cycles, then released
    c0 = cyc;
    u_if.busy = 1'b1;
    u_if.coax_in[0] = 1'b0;
    u_if.coax_in[1] = 1'b0;
    step(1);
    u_if.coax_in = '1;
    step(6);
    u_if.busy = 1'b0;
    push(c0 + 8, 6, 0, 4);
    step(40);
    check("busy_veto", 64'(u_if.veto_count), 64'd4);
    check("busy_count", 64'(u_if.trig_count), 64'd6);

    // Prescale rejects: six candidate cycles vetoed in any-hit mode
    u_if.trig_mode = 2'd2;
    u_if.prescale  = 32'd0;
    u_if.randnum   = 32'd5;
    u_if.coax_in[10] = 1'b0;
    step(1);
    u_if.coax_in = '1;
    step(40);
    check("prescale_veto", 64'(u_if.veto_count), 64'd10);
    check("prescale_count", 64'(u_if.trig_count), 64'd6);

    // randnum equal to prescale passes
    u_if.randnum = 32'd0;
    c0 = cyc;
    push(c0 + 4, 7, 0, 4);
    u_if.coax_in[10] = 1'b0;
    step(1);
    u_if.coax_in = '1;
    step(40);
    check("pass_count", 64'(u_if.trig_count), 64'd7);
    check("pass_veto", 64'(u_if.veto_count), 64'd10);

    // Masked channel never contributes
    u_if.triggermask[10] = 1'b0;
    u_if.coax_in[10] = 1'b0;
    step(1);
    u_if.coax_in = '1;
    step(40);
    u_if.triggermask = '1;
    check("mask_count", 64'(u_if.trig_count), 64'd7);
    check("mask_veto", 64'(u_if.veto_count), 64'd10);

    // Reset in the middle of a pulse while windows are still open
    u_if.trig_mode = 2'd0;
    u_if.prescale  = 32'hFFFF_FFFF;
    u_if.dead_time = 8'd40;
    u_if.out_width = 6'd16;
    c0 = cyc;
    push(c0 + 4, 8, 5, 2);
    hit_col(5);
    step(1);
    u_if.coax_in = '1;
    step(4);
    rst = 1'b1;
    step(1);
    rst_cyc = cyc;
    rst = 1'b0;
    check("midrst_trig_out", 64'(u_if.trig_out), 64'd0);
    check("midrst_count", 64'(u_if.trig_count), 64'd0);
    check("midrst_veto", 64'(u_if.veto_count), 64'd0);
    check("midrst_timestamp", 64'(u_if.trig_timestamp), 64'd0);
    check("midrst_column", 64'(u_if.trig_column), 64'd0);
    step(20);
    check("postrst_count", 64'(u_if.trig_count), 64'd0);

    // Mode 3 never fires, even with every channel hit
    u_if.trig_mode = 2'd3;
    u_if.coax_in = '0;
    step(1);
    u_if.coax_in = '1;
    step(20);
    check("mode3_count", 64'(u_if.trig_count), 64'd0);
    check("mode3_veto", 64'(u_if.veto_count), 64'd0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
